// File: rtl/risc_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a prefetch FIFO, with redirect flush.
// Optional macro FETCH_ALIGN_CHECK_EN adds fetch_misalign and suspends fetch after an odd redirect target.
module risc_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] instr,
  output logic [15:0] pc_current,
  output logic [15:0] pc_next
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [15:0]   r_fetch_pc;
  logic [15:0]   r_disc_addr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_count_after;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic          r_valid;
  logic [15:0]   r_buf_instr [DEPTH];
  logic [15:0]   r_buf_pc    [DEPTH];
  logic          w_ack;
  logic          w_push;
  logic          w_pop;
  logic          w_reissue;
  logic          w_suspend;
  logic [15:0]   w_redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misalign;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (redirect_valid) begin
      r_misalign <= redirect_pc[0];
    end
  end

  assign w_suspend      = r_misalign;
  assign fetch_misalign = r_misalign;
`else
  assign w_suspend = 1'b0;
`endif

  assign w_redirect_pc = redirect_pc & 16'hFFFE;
  assign w_pop         = r_valid & instr_ready;
  assign w_ack         = imem_req & imem_ack;
  assign w_push        = w_ack & (r_state != DISCARD) & ~redirect_valid;
  // Occupancy after this cycle's push completes, used to decide back-to-back reissue.
  assign w_count_after = r_count + CW'(1) - CW'(w_pop);
  assign w_reissue     = (w_count_after < DEPTH_C) & ~w_suspend;

  always_comb begin
    w_count_nxt = r_count;
    if (redirect_valid) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    imem_req    = 1'b0;
    case (r_state)
      IDLE: begin
        imem_req = ~redirect_valid & ~w_suspend & (r_count < DEPTH_C);
        if (imem_req) begin
          w_state_nxt = (imem_ack && !w_reissue) ? IDLE : WAIT;
        end
      end
      WAIT: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          w_state_nxt = imem_ack ? IDLE : DISCARD;
        end else if (imem_ack) begin
          w_state_nxt = w_reissue ? WAIT : IDLE;
        end
      end
      DISCARD: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // Any outstanding request is abandoned while reset is held.
    if (rst) begin
      imem_req    = 1'b0;
      w_state_nxt = IDLE;
    end
  end

  // A dropped request keeps its original address on the bus until it is acked.
  assign imem_addr = (r_state == DISCARD) ? r_disc_addr : r_fetch_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_count    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
      if (redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + 16'd2;
          r_wr_ptr   <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= imem_rdata;
      r_buf_pc[r_wr_ptr]    <= r_fetch_pc;
    end
    if (r_state == WAIT && redirect_valid && !imem_ack) begin
      r_disc_addr <= r_fetch_pc;
    end
  end

  assign instr_valid = r_valid;
  assign instr       = r_valid ? r_buf_instr[r_rd_ptr] : 16'h0000;
  assign pc_current  = r_valid ? r_buf_pc[r_rd_ptr] : r_fetch_pc;
  assign pc_next     = pc_current + 16'd2;

endmodule

// File: tb/tb_risc_fetch_unit.sv
// Bench for risc_fetch_unit: directed scenarios plus a randomized run scored against an instruction-stream model.
module tb_risc_fetch_unit;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [15:0] pc_current;
  logic [15:0] pc_next;
  logic        ack_mode;
  logic        ack_force;

  logic        req2;
  logic [15:0] addr2;
  logic [15:0] rdata2;
  logic        valid2;
  logic [15:0] instr2;
  logic [15:0] pc_cur2;
  logic [15:0] pc_next2;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_misalign;
  logic fetch_misalign2;
`endif

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h5A5A;
  endfunction

  assign imem_ack   = ack_mode ? imem_req : ack_force;
  assign imem_rdata = mem_word(imem_addr);
  assign rdata2     = mem_word(addr2);

  risc_fetch_unit #(.RESET_PC(16'h0000), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .pc_current(pc_current), .pc_next(pc_next)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  risc_fetch_unit #(.RESET_PC(16'hFFFC), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(req2), .imem_rdata(rdata2),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .instr_valid(valid2), .instr_ready(1'b1),
    .instr(instr2), .pc_current(pc_cur2), .pc_next(pc_next2)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "timeout");
  end

  // Holds reset for three cycles and returns at the negedge where the first post-reset cycle begins.
  task automatic do_reset();
    rst = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0;
    ack_mode = 1'b0; ack_force = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 16'h0;
    ack_mode = 1'b0; ack_force = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_checks++; if (imem_addr !== 16'h0000) begin n_errors++; $display("FAIL reset_addr: got %h want 0000", imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_checks++; if (instr !== 16'h0000) begin n_errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
    n_checks++; if (pc_current !== 16'h0000) begin n_errors++; $display("FAIL reset_pc: got %h want 0000", pc_current); end
    n_checks++; if (pc_next !== 16'h0002) begin n_errors++; $display("FAIL reset_pcnext: got %h want 0002", pc_next); end
    n_checks++; if (pc_next2 !== 16'hFFFE) begin n_errors++; $display("FAIL reset_pcnext2: got %h want fffe", pc_next2); end
`ifdef FETCH_ALIGN_CHECK_EN
    n_checks++; if (fetch_misalign !== 1'b0) begin n_errors++; $display("FAIL reset_misalign: got %b want 0", fetch_misalign); end
`endif
    ack_force = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL release_req: got %b want 1", imem_req); end
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL release_no_push: got valid %b want 0", instr_valid); end
  endtask

  task automatic test_zero_wait();
    do_reset();
    ack_mode = 1'b1; instr_ready = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_errors++; $display("FAIL zw_c1: got req %b addr %h want 1 0000", imem_req, imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL zw_c1_valid: got %b want 0", instr_valid); end
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin n_errors++; $display("FAIL zw_c2: got req %b addr %h want 1 0002", imem_req, imem_addr); end
    n_checks++; if (instr_valid !== 1'b1 || pc_current !== 16'h0000 || instr !== mem_word(16'h0000)) begin
      n_errors++; $display("FAIL zw_head0: got v%b pc %h instr %h want v1 pc 0000 instr %h", instr_valid, pc_current, instr, mem_word(16'h0000)); end
    n_checks++; if (pc_next !== 16'h0002) begin n_errors++; $display("FAIL zw_pcnext0: got %h want 0002", pc_next); end
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0004) begin n_errors++; $display("FAIL zw_c3: got req %b addr %h want 1 0004", imem_req, imem_addr); end
    n_checks++; if (pc_current !== 16'h0002 || pc_next !== 16'h0004 || instr !== mem_word(16'h0002)) begin
      n_errors++; $display("FAIL zw_head1: got pc %h next %h instr %h want 0002 0004 %h", pc_current, pc_next, instr, mem_word(16'h0002)); end
  endtask

  task automatic test_backpressure();
    int pushes;
    do_reset();
    ack_mode = 1'b1; instr_ready = 1'b0; pushes = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (imem_req && imem_ack) pushes++;
      @(negedge clk);
    end
    #1;
    n_checks++; if (pushes !== 4) begin n_errors++; $display("FAIL bp_pushes: got %0d want 4", pushes); end
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL bp_req_full: got %b want 0", imem_req); end
    n_checks++; if (instr_valid !== 1'b1 || pc_current !== 16'h0000) begin n_errors++; $display("FAIL bp_head: got v%b pc %h want v1 0000", instr_valid, pc_current); end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin n_errors++; $display("FAIL bp_resume: got req %b addr %h want 1 0008", imem_req, imem_addr); end
    n_checks++; if (pc_current !== 16'h0002) begin n_errors++; $display("FAIL bp_pop: got pc %h want 0002", pc_current); end
  endtask

  task automatic test_redirect_wait();
    bit found;
    do_reset();
    ack_mode = 1'b1; instr_ready = 1'b1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      #1;
      if (imem_req && imem_addr == 16'h0006) begin
        found = 1'b1; ack_mode = 1'b0; ack_force = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    n_checks++; if (found !== 1'b1) begin n_errors++; $display("FAIL rw_reach6: got found %b want 1", found); end
    @(negedge clk); #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin n_errors++; $display("FAIL rw_hold: got req %b addr %h want 1 0006", imem_req, imem_addr); end
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    @(negedge clk);
    redirect_valid = 1'b0; ack_force = 1'b1;
    #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rw_flush: got valid %b want 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin n_errors++; $display("FAIL rw_discard_hold: got req %b addr %h want 1 0006", imem_req, imem_addr); end
    @(negedge clk);
    ack_force = 1'b0; ack_mode = 1'b1;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_errors++; $display("FAIL rw_target: got req %b addr %h want 1 0040", imem_req, imem_addr); end
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL rw_dropped: got valid %b want 0", instr_valid); end
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b1 || pc_current !== 16'h0040 || instr !== mem_word(16'h0040)) begin
      n_errors++; $display("FAIL rw_first: got v%b pc %h instr %h want v1 0040 %h", instr_valid, pc_current, instr, mem_word(16'h0040)); end
  endtask

  task automatic test_redirect_ack();
    do_reset();
    ack_mode = 1'b1; instr_ready = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 16'h0100;
    #1;
    n_checks++; if (imem_req !== 1'b1 || imem_ack !== 1'b1 || imem_addr !== 16'h0002) begin
      n_errors++; $display("FAIL ra_coincide: got req %b ack %b addr %h want 1 1 0002", imem_req, imem_ack, imem_addr); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_errors++; $display("FAIL ra_flush: got valid %b want 0", instr_valid); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin n_errors++; $display("FAIL ra_target: got req %b addr %h want 1 0100", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b1 || pc_current !== 16'h0100 || instr !== mem_word(16'h0100)) begin
      n_errors++; $display("FAIL ra_first: got v%b pc %h instr %h want v1 0100 %h", instr_valid, pc_current, instr, mem_word(16'h0100)); end
  endtask

  task automatic test_align();
    do_reset();
    ack_mode = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 16'h0041;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    begin
      int reqs;
      reqs = 0;
      n_checks++; if (fetch_misalign !== 1'b1) begin n_errors++; $display("FAIL al_flag: got %b want 1", fetch_misalign); end
      for (int i = 0; i < 4; i++) begin
        if (imem_req) reqs++;
        @(negedge clk); #1;
      end
      n_checks++; if (reqs !== 0) begin n_errors++; $display("FAIL al_suspend: got %0d requests want 0", reqs); end
      redirect_valid = 1'b1; redirect_pc = 16'h0040;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_checks++; if (fetch_misalign !== 1'b0) begin n_errors++; $display("FAIL al_clear: got %b want 0", fetch_misalign); end
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_errors++; $display("FAIL al_resume: got req %b addr %h want 1 0040", imem_req, imem_addr); end
    end
`else
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_errors++; $display("FAIL al_force_even: got req %b addr %h want 1 0040", imem_req, imem_addr); end
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b1 || pc_current !== 16'h0040) begin n_errors++; $display("FAIL al_head: got v%b pc %h want v1 0040", instr_valid, pc_current); end
`endif
  endtask

  task automatic test_wrap();
    do_reset();
    #1;
    n_checks++; if (req2 !== 1'b1 || addr2 !== 16'hFFFC) begin n_errors++; $display("FAIL wr_c1: got req %b addr %h want 1 fffc", req2, addr2); end
    @(negedge clk); #1;
    n_checks++; if (addr2 !== 16'hFFFE || pc_cur2 !== 16'hFFFC) begin n_errors++; $display("FAIL wr_c2: got addr %h pc %h want fffe fffc", addr2, pc_cur2); end
    @(negedge clk); #1;
    n_checks++; if (addr2 !== 16'h0000 || pc_cur2 !== 16'hFFFE) begin n_errors++; $display("FAIL wr_c3: got addr %h pc %h want 0000 fffe", addr2, pc_cur2); end
    n_checks++; if (pc_next2 !== 16'h0000) begin n_errors++; $display("FAIL wr_pcnext: got %h want 0000", pc_next2); end
  endtask

  // The decoded stream must be consecutive words from the latest redirect target, whatever the timing.
  task automatic test_random();
    logic [15:0] exp_pc;
    logic        prev_pending;
    logic [15:0] prev_addr;
    int          pops;
    int          stream_err;
    int          hold_err;
    do_reset();
    ack_mode = 1'b0;
    exp_pc = 16'h0000; prev_pending = 1'b0; prev_addr = 16'h0; pops = 0;
    stream_err = 0; hold_err = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      ack_force      = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 99) < 3);
      redirect_pc    = 16'($urandom) & 16'hFFFE;
      #1;
      if (prev_pending) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_errors++; hold_err++;
          if (hold_err <= 5) $display("FAIL rnd_hold cyc %0d: got req %b addr %h want 1 %h", cyc, imem_req, imem_addr, prev_addr);
        end
      end
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (pc_current !== exp_pc || instr !== mem_word(exp_pc) || pc_next !== exp_pc + 16'd2) begin
          n_errors++; stream_err++;
          if (stream_err <= 5) $display("FAIL rnd_stream cyc %0d: got pc %h instr %h next %h want %h %h %h",
                                        cyc, pc_current, instr, pc_next, exp_pc, mem_word(exp_pc), exp_pc + 16'd2);
        end
        exp_pc = exp_pc + 16'd2;
        pops++;
      end
      if (redirect_valid) exp_pc = redirect_pc & 16'hFFFE;
      prev_pending = imem_req && !imem_ack;
      prev_addr    = imem_addr;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    n_checks++; if (pops < 200) begin n_errors++; $display("FAIL rnd_progress: got %0d pops want at least 200", pops); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack();
    test_align();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/risc_fetch_unit.md
RISC_FETCH_UNIT -- requirements
Module: risc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000, address of the first fetch after reset.
REQ-002 SHALL have parameter DEPTH, default 4, prefetch buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-006 SHALL have port imem_addr  output  16  byte address of requested instruction.
REQ-007 SHALL have port imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-008 SHALL have port imem_rdata  input  16  instruction word.
REQ-009 SHALL have port redirect_valid  input  1  jump/taken-branch redirect from execute.
REQ-010 SHALL have port redirect_pc  input  16  redirect target.
REQ-011 SHALL have port instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port instr_ready  input  1  decode accepts head instruction.
REQ-013 SHALL have port instr  output  16  head instruction word.
REQ-014 SHALL have port pc_current  output  16  address of head instruction.
REQ-015 SHALL have port pc_next  output  16  pc_current + 2, modulo 2^16.

Function
REQ-016 SHALL keep fetch_pc register; imem_addr equals fetch_pc whenever imem_req is high.
REQ-017 SHALL allow at most one outstanding request; imem_req and imem_addr held stable until imem_ack.
REQ-018 SHALL sample imem_ack only while imem_req is high; ack may arrive in the first request cycle.
REQ-019 SHALL issue a request only when buffer count plus outstanding requests < DEPTH.
REQ-020 SHALL, on accepted ack, push {fetch_pc, imem_rdata} and advance fetch_pc by 2 (16'hFFFE wraps to 16'h0000).
REQ-021 SHALL re-assert imem_req the cycle after an ack when space remains: zero-wait memory sustains one instruction per cycle.
REQ-022 SHALL use FSM states IDLE (no request), WAIT (request outstanding), DISCARD (outstanding request whose data is dropped).
REQ-023 SHALL transition IDLE->WAIT on issue; WAIT->IDLE on ack with no further issue; WAIT->WAIT on ack with immediate reissue; WAIT->DISCARD on redirect without same-cycle ack; DISCARD->IDLE on ack.
REQ-024 SHALL present instr_valid registered, asserted the cycle after the first push into an empty buffer.
REQ-025 SHALL pop head when instr_valid and instr_ready; push and pop in the same cycle keep count unchanged.
REQ-026 SHALL, on redirect_valid, flush the buffer (instr_valid low next cycle) and load fetch_pc with redirect_pc.
REQ-027 SHALL drop imem_rdata on a redirect coinciding with ack; redirect wins; fetch_pc takes redirect_pc.
REQ-028 SHALL, on redirect during DISCARD, update fetch_pc again and remain in DISCARD.
REQ-029 SHALL complete a pop coinciding with redirect (decode consumed it), then flush.
REQ-030 SHALL issue the first post-redirect request no earlier than the cycle after redirect, at the new fetch_pc.

Reset
REQ-031 SHALL on rst: fetch_pc=RESET_PC, state=IDLE, buffer empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, pc_current=RESET_PC, pc_next=RESET_PC+2.
REQ-032 SHALL abandon any outstanding request on rst; an imem_ack during or after reset with imem_req low is ignored.
REQ-033 SHALL assert imem_req in the first cycle after rst deasserts.

Configuration
REQ-034 SHALL, with FETCH_ALIGN_CHECK_EN defined, add output fetch_misalign (1): set and held when redirect_pc[0]=1, fetch suspended (no requests) until rst or an aligned redirect.
REQ-035 SHALL, without FETCH_ALIGN_CHECK_EN, omit fetch_misalign and force redirect_pc[0] to 0.

Verification
REQ-036 SHALL cover reset release, zero-wait ack, instr_ready=1 -> addresses 0000,0002,0004 on consecutive cycles; instr_valid from cycle 2; pc_next=pc_current+2.
REQ-037 SHALL cover instr_ready=0 with DEPTH=4 -> exactly 4 pushes, imem_req low, count held until a pop.
REQ-038 SHALL cover redirect_pc=16'h0040 while request to 0006 waits 3 cycles -> 0006 data dropped, next imem_addr 0040, first valid pc_current 0040.
REQ-039 SHALL cover redirect coincident with ack -> ack data discarded, no buffer entry, next request at target.
REQ-040 SHALL cover RESET_PC=16'hFFFC -> fetch sequence FFFC, FFFE, 0000; pc_next at FFFE equals 0000.
REQ-041 SHALL cover redirect_pc=16'h0041 with FETCH_ALIGN_CHECK_EN -> fetch_misalign=1, imem_req stays low; without it -> fetch at 0040.
